alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 75 +++++++
 rtl/alu_issue_dec.sv | 107 ++++++++++
 rtl/alu_issue.sv | 126 ++++++++++++
 tb/tb_alu_issue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32I integer ALU path:
//   - alu_op_e       : ALU operation encoding used by alu_issue and the ALU
//   - OPC_* / F3_* / F7_* : RV32I opcode, funct3 and funct7 constants
//   - issue_entry_t  : one decoded entry as held in the issue storage
//   - f3_to_op()     : funct3 (+ alternate funct7 flag) to ALU op mapping
//   - is_shift_op()  : true for SLL/SRL/SRA
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_AND  = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } issue_entry_t;

   localparam issue_entry_t ENTRY_RST = '{op: 4'd0, a: 32'd0, b: 32'd0,
                                          rd: 5'd0, we: 1'b0, illegal: 1'b0};

   // alt selects SUB for funct3=000 and SRA for funct3=101; ignored elsewhere.
   function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         F3_AND:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic is_shift_op(input alu_op_e op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// ---------------------------------------------------------------------------
// alu_issue_dec
// Purely combinational RV32I ALU-class decoder (OP, OP-IMM, LUI, AUIPC).
// Ports:
//   instr_i, pc_i, rs1_data_i, rs2_data_i : instruction word and its sources
//   alu_op_o, operand_a_o, operand_b_o     : ALU op and operands
//   rd_addr_o, rd_we_o                     : destination and write enable
//   illegal_o                              : instruction not handled here
// Illegal instructions produce ADD with zero operands and no write.
// ---------------------------------------------------------------------------
module alu_issue_dec
   import alu_pkg::*;
#(
   parameter bit MASK_SHAMT = 1'b1
) (
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   output logic [3:0]  alu_op_o,
   output logic [31:0] operand_a_o,
   output logic [31:0] operand_b_o,
   output logic [4:0]  rd_addr_o,
   output logic        rd_we_o,
   output logic        illegal_o
);

   logic [6:0]  opcode_s;
   logic [2:0]  f3_s;
   logic [6:0]  f7_s;
   logic [4:0]  rd_s;
   logic [31:0] imm_i_s;
   logic [31:0] imm_u_s;

   assign opcode_s = instr_i[6:0];
   assign f3_s     = instr_i[14:12];
   assign f7_s     = instr_i[31:25];
   assign rd_s     = instr_i[11:7];
   assign imm_i_s  = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_u_s  = {instr_i[31:12], 12'd0};

   alu_op_e     op_s;
   logic [31:0] a_s;
   logic [31:0] b_s;
   logic        legal_s;

   // Field decode, legality check and shift-amount masking.
   always_comb begin
      op_s    = ALU_ADD;
      a_s     = 32'd0;
      b_s     = 32'd0;
      legal_s = 1'b0;
      case (opcode_s)
         OPC_OP: begin
            a_s     = rs1_data_i;
            b_s     = rs2_data_i;
            op_s    = f3_to_op(f3_s, f7_s == F7_ALT);
            legal_s = (f7_s == F7_BASE) ||
                      ((f7_s == F7_ALT) && ((f3_s == F3_ADD) || (f3_s == F3_SR)));
         end
         OPC_OP_IMM: begin
            a_s  = rs1_data_i;
            b_s  = imm_i_s;
            // funct7 only exists for immediate shifts; ADDI etc. use those bits as imm.
            op_s = f3_to_op(f3_s, (f3_s == F3_SR) && (f7_s == F7_ALT));
            if (f3_s == F3_SLL) begin
               legal_s = (f7_s == F7_BASE);
            end else if (f3_s == F3_SR) begin
               legal_s = (f7_s == F7_BASE) || (f7_s == F7_ALT);
            end else begin
               legal_s = 1'b1;
            end
         end
         OPC_LUI: begin
            a_s     = 32'd0;
            b_s     = imm_u_s;
            legal_s = 1'b1;
         end
         OPC_AUIPC: begin
            a_s     = pc_i;
            b_s     = imm_u_s;
            legal_s = 1'b1;
         end
         default: begin
            legal_s = 1'b0;
         end
      endcase

      if (!legal_s) begin
         op_s = ALU_ADD;
         a_s  = 32'd0;
         b_s  = 32'd0;
      end else if (MASK_SHAMT && is_shift_op(op_s)) begin
         b_s = {27'd0, b_s[4:0]};
      end else begin
         b_s = b_s;
      end
   end

   assign alu_op_o    = op_s;
   assign operand_a_o = a_s;
   assign operand_b_o = b_s;
   assign rd_addr_o   = rd_s;
   assign rd_we_o     = legal_s && (rd_s != 5'd0);
   assign illegal_o   = ~legal_s;

endmodule

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Decodes RV32I ALU instructions and issues them through a two-entry
// elastic buffer (output register + skid register) with valid/ready
// handshakes on both sides.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   flush_i            : synchronous discard of all held entries
//   in_valid_i/in_ready_o, instr_i, pc_i, rs1_data_i, rs2_data_i : upstream
//   out_valid_o/out_ready_i, alu_op_o, operand_a_o, operand_b_o,
//   rd_addr_o, rd_we_o, illegal_o                                : downstream
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module alu_issue
   import alu_pkg::*;
#(
   parameter bit MASK_SHAMT = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [3:0]  alu_op_o,
   output logic [31:0] operand_a_o,
   output logic [31:0] operand_b_o,
   output logic [4:0]  rd_addr_o,
   output logic        rd_we_o,
   output logic        illegal_o
);

   issue_entry_t dec_entry_s;

   alu_issue_dec #(
      .MASK_SHAMT (MASK_SHAMT)
   ) u_dec (
      .instr_i     (instr_i),
      .pc_i        (pc_i),
      .rs1_data_i  (rs1_data_i),
      .rs2_data_i  (rs2_data_i),
      .alu_op_o    (dec_entry_s.op),
      .operand_a_o (dec_entry_s.a),
      .operand_b_o (dec_entry_s.b),
      .rd_addr_o   (dec_entry_s.rd),
      .rd_we_o     (dec_entry_s.we),
      .illegal_o   (dec_entry_s.illegal)
   );

   issue_entry_t out_q, out_d;
   issue_entry_t skid_q, skid_d;
   logic         out_valid_q, out_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic         in_ready_q, in_ready_d;

   logic in_fire_s;
   logic out_fire_s;

   assign in_fire_s  = in_valid_i & in_ready_q;
   assign out_fire_s = out_valid_q & out_ready_i;

   // Buffer next state: the output register refills from skid first, then
   // from the decoder; skid only captures while the output register stalls.
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_fire_s) begin
         if (skid_valid_q) begin
            // in_ready_q is low here, so no new entry can arrive this cycle.
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire_s) begin
            out_d       = dec_entry_s;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         if (in_fire_s) begin
            skid_d       = dec_entry_s;
            skid_valid_d = 1'b1;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
      in_ready_d = ~skid_valid_d;
   end

   // Storage and handshake state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q        <= ENTRY_RST;
         skid_q       <= ENTRY_RST;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign alu_op_o    = out_q.op;
   assign operand_a_o = out_q.a;
   assign operand_b_o = out_q.b;
   assign rd_addr_o   = out_q.rd;
   assign rd_we_o     = out_q.we;
   assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
// Directed self-checking bench for alu_issue. Inputs change 1 time unit
// after the rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_alu_issue;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] instr_i;
   logic [31:0] pc_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [3:0]  alu_op_o;
   logic [31:0] operand_a_o;
   logic [31:0] operand_b_o;
   logic [4:0]  rd_addr_o;
   logic        rd_we_o;
   logic        illegal_o;

   int vectors     = 0;
   int miscompares = 0;

   alu_issue #(.MASK_SHAMT(1'b1)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .instr_i     (instr_i),
      .pc_i        (pc_i),
      .rs1_data_i  (rs1_data_i),
      .rs2_data_i  (rs2_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .alu_op_o    (alu_op_o),
      .operand_a_o (operand_a_o),
      .operand_b_o (operand_b_o),
      .rd_addr_o   (rd_addr_o),
      .rd_we_o     (rd_we_o),
      .illegal_o   (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic we,
                          input logic ill);
      chk({tag, ".valid"}, {31'd0, out_valid_o}, 32'd1);
      chk({tag, ".op"},    {28'd0, alu_op_o},    {28'd0, op});
      chk({tag, ".a"},     operand_a_o,          a);
      chk({tag, ".b"},     operand_b_o,          b);
      chk({tag, ".rd"},    {27'd0, rd_addr_o},   {27'd0, rd});
      chk({tag, ".we"},    {31'd0, rd_we_o},     {31'd0, we});
      chk({tag, ".ill"},   {31'd0, illegal_o},   {31'd0, ill});
   endtask

   // Present one entry for exactly one rising edge, then withdraw it.
   task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
      instr_i    = instr;
      pc_i       = pc;
      rs1_data_i = rs1;
      rs2_data_i = rs2;
      in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni      = 1'b0;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      instr_i     = 32'd0;
      pc_i        = 32'd0;
      rs1_data_i  = 32'd0;
      rs2_data_i  = 32'd0;
      #12;
      chk("rst.valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst.ready", {31'd0, in_ready_o},  32'd1);
      chk("rst.op",    {28'd0, alu_op_o},    32'd0);
      chk("rst.a",     operand_a_o,          32'd0);
      chk("rst.b",     operand_b_o,          32'd0);
      chk("rst.rd",    {27'd0, rd_addr_o},   32'd0);
      chk("rst.we",    {31'd0, rd_we_o},     32'd0);
      chk("rst.ill",   {31'd0, illegal_o},   32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Decode vectors, out_ready held high (back-to-back at occupancy 1).
      send(32'h002081B3, 32'h0, 32'd5, 32'd7);          // add x3,x1,x2
      chk_out("add", 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
      send(32'h40335293, 32'h0, 32'h80000000, 32'd0);   // srai x5,x6,3
      chk_out("srai", 4'd9, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0);
      send(32'h00209233, 32'h0, 32'd9, 32'h25);         // sll x4,x1,x2
      chk_out("sll", 4'd7, 32'd9, 32'd5, 5'd4, 1'b1, 1'b0);
      send(32'h12345097, 32'h100, 32'd0, 32'd0);        // auipc x1
      chk_out("auipc", 4'd0, 32'h100, 32'h12345000, 5'd1, 1'b1, 1'b0);
      send(32'h40208133, 32'h0, 32'd10, 32'd3);         // sub x2,x1,x2
      chk_out("sub", 4'd1, 32'd10, 32'd3, 5'd2, 1'b1, 1'b0);
      send(32'hABCDE0B7, 32'h0, 32'h55, 32'h66);        // lui x1
      chk_out("lui", 4'd0, 32'd0, 32'hABCDE000, 5'd1, 1'b1, 1'b0);
      send(32'hFFF08013, 32'h0, 32'd4, 32'd0);          // addi x0,x1,-1
      chk_out("addi_x0", 4'd0, 32'd4, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0);
      send(32'h0000006F, 32'h40, 32'd1, 32'd2);         // jal x0
      chk_out("jal", 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
      send(32'h022081B3, 32'h0, 32'd1, 32'd2);          // funct7=0000001
      chk_out("f7bad", 4'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
      send(32'h4020E1B3, 32'h0, 32'd1, 32'd2);          // funct7 alt with OR
      chk_out("altor", 4'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
      idle();
      chk("drain.valid", {31'd0, out_valid_o}, 32'd0);

      // Backpressure: two entries fill both slots, third is refused.
      out_ready_i = 1'b0;
      send(32'h002081B3, 32'h0, 32'h1, 32'h2);
      chk("bp1.ready", {31'd0, in_ready_o}, 32'd1);
      chk("bp1.a", operand_a_o, 32'h1);
      send(32'h002081B3, 32'h0, 32'h11, 32'h22);
      chk("bp2.ready", {31'd0, in_ready_o}, 32'd0);
      chk("bp2.a", operand_a_o, 32'h1);
      instr_i    = 32'h002081B3;
      rs1_data_i = 32'h33;
      in_valid_i = 1'b1;
      idle();
      in_valid_i = 1'b0;
      chk_out("bp3", 4'd0, 32'h1, 32'h2, 5'd3, 1'b1, 1'b0);
      out_ready_i = 1'b1;
      idle();
      chk_out("rel1", 4'd0, 32'h11, 32'h22, 5'd3, 1'b1, 1'b0);
      chk("rel1.ready", {31'd0, in_ready_o}, 32'd1);
      idle();
      chk("rel2.valid", {31'd0, out_valid_o}, 32'd0);

      // Flush at occupancy 2 drops everything, including the flush-cycle input.
      out_ready_i = 1'b0;
      send(32'h002081B3, 32'h0, 32'h1, 32'h2);
      send(32'h002081B3, 32'h0, 32'h3, 32'h4);
      chk("pre_flush.ready", {31'd0, in_ready_o}, 32'd0);
      flush_i    = 1'b1;
      in_valid_i = 1'b1;
      idle();
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      chk("flush.valid", {31'd0, out_valid_o}, 32'd0);
      chk("flush.ready", {31'd0, in_ready_o},  32'd1);
      out_ready_i = 1'b1;
      idle();
      chk("post_flush.valid", {31'd0, out_valid_o}, 32'd0);

      // Asynchronous reset while an entry is held.
      out_ready_i = 1'b0;
      send(32'h002081B3, 32'h0, 32'h7, 32'h8);
      chk("prerst.valid", {31'd0, out_valid_o}, 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst.valid", {31'd0, out_valid_o}, 32'd0);
      chk("arst.ready", {31'd0, in_ready_o},  32'd1);
      chk("arst.a",     operand_a_o,          32'd0);
      chk("arst.we",    {31'd0, rd_we_o},     32'd0);
      @(negedge clk_i);
      rst_ni      = 1'b1;
      out_ready_i = 1'b1;
      send(32'h00209233, 32'h0, 32'd2, 32'h3F);          // sll, shamt masked to 31
      chk_out("postrst", 4'd7, 32'd2, 32'd31, 5'd4, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
